mouse_spinner: RTL and testbench
================================

MOUSE_SPINNER -- requirements
Module: mouse_spinner

Interface
REQ-001 Parameter STEP_DIV, default 16'd700: clk7_en ticks between quadrature steps (about 10 kHz max step rate at 7 MHz).
REQ-002 Parameter DIR_INV, default 1'b0: when 1, inverts the step direction.
REQ-003 Parameter PEND_MAX, default 10'sd511: saturation magnitude of the pending-step accumulator.
REQ-004 clk  input  1  28 MHz system clock, rising edge.
REQ-005 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-006 clk7_en  input  1  clock enable; all state advances only when clk7_en=1.
REQ-007 xcount  input  8  wrapping mouse X position counter from the upstream PS/2 mouse decoder.
REQ-008 _mleft  input  1  left button, active-low, from the mouse decoder.
REQ-009 _mright  input  1  right button, active-low, from the mouse decoder.
REQ-010 spin_a  output  1  spinner quadrature phase A.
REQ-011 spin_b  output  1  spinner quadrature phase B.
REQ-012 spin_dir  output  1  direction of the last issued step; 1 = positive.
REQ-013 busy  output  1  high while the pending accumulator is nonzero.
REQ-014 fire_n  output  1  registered _mleft, active-low.
REQ-015 start_n  output  1  registered _mright, active-low.

Function
REQ-016 The block SHALL keep the following state: prev_x (8 bits); primed (1 bit); pend (signed 10 bits); tmr (16 bits); phase (2 bits).
REQ-017 On every clk7_en with primed=0, the block SHALL load prev_x<=xcount and set primed<=1, without accumulating.
REQ-018 On every clk7_en with primed=1, the block SHALL compute delta = xcount - prev_x as an 8-bit wrap-around difference, interpret it as signed (-128..+127), and then set prev_x<=xcount.
REQ-019 When tmr reaches STEP_DIV-1 on a clk7_en, the timer SHALL issue a step tick and reload tmr to 0; otherwise it SHALL increment tmr. The timer SHALL run continuously.
REQ-020 On a step tick with pend!=0, the block SHALL step once toward zero by 1, as follows:
- Step direction d = sign(pend) XOR DIR_INV.
- phase advances along the Gray sequence 00->01->11->10->00 when d is positive, and in reverse when d is negative.
- spin_dir is set to d.
REQ-021 The update pend_next = sat(pend + delta - step) SHALL be applied in one clk7_en cycle. Both a new delta and a step tick occurring in the same cycle SHALL be honoured. Saturation clamps to the range ±PEND_MAX.
REQ-022 The outputs SHALL map as {spin_b,spin_a} = phase. The outputs SHALL be registered, so phase changes appear one clk cycle after the enabling clk7_en edge.
REQ-023 With pend=0, a step tick SHALL leave phase, spin_dir and pend unchanged.
REQ-024 busy SHALL equal (pend!=0) and SHALL be registered.
REQ-025 fire_n and start_n SHALL be sampled on every clk7_en with no debounce; upstream is already synchronous.
REQ-026 Wrap-around rules:
- An xcount change from 8'hFF to 8'h00 SHALL give delta=+1.
- An xcount change from 8'h00 to 8'hFF SHALL give delta=-1.
REQ-027 Idle cycles (clk7_en=0) SHALL hold all state.

Reset
REQ-028 While reset=1, regardless of clk or clk7_en, the block SHALL hold:
- spin_a=0, spin_b=0, spin_dir=1, busy=0
- fire_n=1, start_n=1
- prev_x=0, primed=0, pend=0, tmr=0, phase=00
REQ-029 Reset asserted mid-sequence SHALL discard pending steps and SHALL NOT emit a partial phase transition.
REQ-030 After reset deasserts, the first xcount value SHALL be absorbed without generating steps (REQ-017). An upstream counter that is nonzero at release therefore SHALL NOT cause a spurious spin.

Verification
REQ-031 Initial load: reset, release, hold xcount=8'h40 -> no phase change over 10*STEP_DIV ticks; busy=0.
REQ-032 Positive steps: after priming at 8'h10, set xcount=8'h13 -> exactly 3 steps, one per STEP_DIV ticks; {b,a}=01,11,10; spin_dir=1; busy falls after the third step.
REQ-033 Wrap and negative steps: prime at 8'h01, then xcount 8'h01->8'hFE -> delta=-3; 3 reverse steps from 00: 10,11,01; spin_dir=0.
REQ-034 Saturation: apply a +127 delta five times within one step period -> pend clamps at 511; exactly 511 steps then follow.
REQ-035 Simultaneous events: a delta of +1 arrives on the same tick as a step with pend=1 -> pend stays 1 and one step is emitted; busy remains 1.
REQ-036 Reset mid-run: assert reset with pend=200 -> outputs go to reset values immediately; after release, no steps occur until xcount changes again.

Source files
------------

// File: rtl/mouse_spinner.sv
// Converts PS/2 mouse X motion into a rate-limited quadrature spinner signal.
// Motion accumulates into a saturating pending count that drains one Gray step per STEP_DIV ticks.
module mouse_spinner #(
   parameter logic [15:0]       STEP_DIV = 16'd700,
   parameter logic              DIR_INV  = 1'b0,
   parameter logic signed [9:0] PEND_MAX = 10'sd511
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clk7_en,
   input  logic [7:0] xcount,
   input  logic       _mleft,
   input  logic       _mright,
   output logic       spin_a,
   output logic       spin_b,
   output logic       spin_dir,
   output logic       busy,
   output logic       fire_n,
   output logic       start_n
);

   logic [7:0]        prev_x_q;
   logic              primed_q;
   logic signed [9:0] pend_q, pend_d;
   logic [15:0]       tmr_q, tmr_d;
   logic [1:0]        phase_q, phase_d;
   logic              dir_q, dir_d;
   logic              busy_q;
   logic              fire_q;
   logic              start_q;

   logic [7:0]         diff;
   logic signed [7:0]  delta;
   logic               step_tick;
   logic               do_step;
   logic               step_pos;
   logic               d;
   logic signed [10:0] step_val;
   logic signed [10:0] sum;
   logic signed [10:0] pmax;

   always_comb begin
      diff      = xcount - prev_x_q;
      delta     = primed_q ? $signed(diff) : 8'sd0;
      step_tick = (tmr_q == STEP_DIV - 16'd1);
      tmr_d     = step_tick ? 16'd0 : tmr_q + 16'd1;
      do_step   = step_tick && (pend_q != 10'sd0);
      // Nonzero pend with a clear sign bit is strictly positive.
      step_pos  = ~pend_q[9];
      d         = step_pos ^ DIR_INV;
      step_val  = 11'sd0;
      if (do_step) step_val = step_pos ? 11'sd1 : -11'sd1;

      pmax = {PEND_MAX[9], PEND_MAX};
      sum  = {pend_q[9], pend_q} + {{3{delta[7]}}, delta} - step_val;
      if (sum > pmax)       pend_d = PEND_MAX;
      else if (sum < -pmax) pend_d = -PEND_MAX;
      else                  pend_d = sum[9:0];

      phase_d = phase_q;
      dir_d   = dir_q;
      if (do_step) begin
         dir_d = d;
         if (d) begin
            unique case (phase_q)
               2'b00: phase_d = 2'b01;
               2'b01: phase_d = 2'b11;
               2'b11: phase_d = 2'b10;
               2'b10: phase_d = 2'b00;
            endcase
         end else begin
            unique case (phase_q)
               2'b00: phase_d = 2'b10;
               2'b10: phase_d = 2'b11;
               2'b11: phase_d = 2'b01;
               2'b01: phase_d = 2'b00;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_x_q <= 8'h00;
         primed_q <= 1'b0;
         pend_q   <= 10'sd0;
         tmr_q    <= 16'd0;
         phase_q  <= 2'b00;
         dir_q    <= 1'b1;
         busy_q   <= 1'b0;
         fire_q   <= 1'b1;
         start_q  <= 1'b1;
      end else if (clk7_en) begin
         prev_x_q <= xcount;
         primed_q <= 1'b1;
         pend_q   <= pend_d;
         tmr_q    <= tmr_d;
         phase_q  <= phase_d;
         dir_q    <= dir_d;
         busy_q   <= (pend_d != 10'sd0);
         fire_q   <= _mleft;
         start_q  <= _mright;
      end
   end

   assign spin_a   = phase_q[0];
   assign spin_b   = phase_q[1];
   assign spin_dir = dir_q;
   assign busy     = busy_q;
   assign fire_n   = fire_q;
   assign start_n  = start_q;

endmodule

// File: tb/tb_mouse_spinner.sv
// Directed bench for mouse_spinner with a short step period; clk7_en pulses once every 4 clocks.
module tb_mouse_spinner;

   localparam int S = 8;

   logic       clk = 1'b0;
   logic       reset;
   logic       clk7_en;
   logic [7:0] xcount;
   logic       _mleft;
   logic       _mright;
   logic       spin_a, spin_b, spin_dir, busy, fire_n, start_n;

   int checks   = 0;
   int failures = 0;
   int k        = 0;
   logic [1:0] gray [4];

   mouse_spinner #(
      .STEP_DIV (16'(S)),
      .DIR_INV  (1'b0),
      .PEND_MAX (10'sd511)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .clk7_en  (clk7_en),
      .xcount   (xcount),
      ._mleft   (_mleft),
      ._mright  (_mright),
      .spin_a   (spin_a),
      .spin_b   (spin_b),
      .spin_dir (spin_dir),
      .busy     (busy),
      .fire_n   (fire_n),
      .start_n  (start_n)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One enabled clock followed by three idle clocks; returns #1 after an edge.
   task automatic tick();
      clk7_en = 1'b1;
      @(posedge clk);
      #1;
      clk7_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      k++;
   endtask

   task automatic do_reset(input logic [7:0] x);
      reset   = 1'b1;
      xcount  = x;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      k     = 0;
   endtask

   initial begin
      gray[0] = 2'b00; gray[1] = 2'b01; gray[2] = 2'b11; gray[3] = 2'b10;
      reset   = 1'b1;
      clk7_en = 1'b1;
      xcount  = 8'h55;
      _mleft  = 1'b0;
      _mright = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_phase", {30'd0, spin_b, spin_a}, 32'd0);
      chk("rst_dir", {31'd0, spin_dir}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_fire", {31'd0, fire_n}, 32'd1);
      chk("rst_start", {31'd0, start_n}, 32'd1);
      clk7_en = 1'b0;
      _mleft  = 1'b1;
      _mright = 1'b1;

      // Initial load: nonzero counter at release must not spin
      do_reset(8'h40);
      for (int i = 0; i < 10 * S; i++) begin
         tick();
         chk("load_idle", {29'd0, spin_b, spin_a, busy}, 32'd0);
      end

      // Buttons registered on enable, held while idle
      _mleft = 1'b0; _mright = 1'b0;
      tick();
      chk("btn_fire_lo", {31'd0, fire_n}, 32'd0);
      chk("btn_start_lo", {31'd0, start_n}, 32'd0);
      _mleft = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("btn_hold", {31'd0, fire_n}, 32'd0);
      _mright = 1'b1;
      tick();
      chk("btn_fire_hi", {31'd0, fire_n}, 32'd1);
      chk("btn_start_hi", {31'd0, start_n}, 32'd1);

      // Positive steps: 0x10 -> 0x13
      do_reset(8'h10);
      tick();
      xcount = 8'h13;
      while (k < 4 * S) begin
         int n;
         tick();
         n = (k / S > 3) ? 3 : k / S;
         chk("pos_phase", {30'd0, spin_b, spin_a}, {30'd0, gray[n]});
         chk("pos_busy", {31'd0, busy}, (k >= 2 && k < 3 * S) ? 32'd1 : 32'd0);
         chk("pos_dir", {31'd0, spin_dir}, 32'd1);
      end

      // Wrap-around: FF->00 is +1, 00->FF is -1
      do_reset(8'hFF);
      tick();
      xcount = 8'h00;
      tick();
      chk("wrap_up_busy", {31'd0, busy}, 32'd1);
      xcount = 8'hFF;
      tick();
      chk("wrap_dn_busy", {31'd0, busy}, 32'd0);
      chk("wrap_phase", {30'd0, spin_b, spin_a}, 32'd0);

      // Negative steps: 0x01 -> 0xFE is -3
      do_reset(8'h01);
      tick();
      xcount = 8'hFE;
      while (k < 4 * S) begin
         int n;
         tick();
         n = (k / S > 3) ? 3 : k / S;
         chk("neg_phase", {30'd0, spin_b, spin_a}, {30'd0, gray[(4 - n) % 4]});
         chk("neg_busy", {31'd0, busy}, (k >= 2 && k < 3 * S) ? 32'd1 : 32'd0);
         chk("neg_dir", {31'd0, spin_dir}, (k < S) ? 32'd1 : 32'd0);
      end

      // Delta and step on the same tick with pend=1
      do_reset(8'h20);
      tick();
      xcount = 8'h21;
      while (k < S - 1) tick();
      xcount = 8'h22;
      tick();
      chk("sim_phase", {30'd0, spin_b, spin_a}, 32'd1);
      chk("sim_busy", {31'd0, busy}, 32'd1);
      while (k < 2 * S - 1) tick();
      chk("sim_busy_pre", {31'd0, busy}, 32'd1);
      tick();
      chk("sim_phase2", {30'd0, spin_b, spin_a}, 32'd3);
      chk("sim_busy_end", {31'd0, busy}, 32'd0);

      // Saturation: five +127 deltas before the first step
      do_reset(8'h00);
      tick();
      for (int i = 0; i < 5; i++) begin
         xcount = xcount + 8'd127;
         tick();
      end
      chk("sat_busy", {31'd0, busy}, 32'd1);
      while (k < 511 * S - 1) tick();
      chk("sat_busy_510", {31'd0, busy}, 32'd1);
      chk("sat_phase_510", {30'd0, spin_b, spin_a}, {30'd0, gray[510 % 4]});
      tick();
      chk("sat_busy_511", {31'd0, busy}, 32'd0);
      chk("sat_phase_511", {30'd0, spin_b, spin_a}, {30'd0, gray[511 % 4]});
      repeat (2 * S) tick();
      chk("sat_phase_after", {30'd0, spin_b, spin_a}, {30'd0, gray[511 % 4]});

      // Reset mid-run with pend=200
      do_reset(8'h00);
      tick();
      xcount = 8'd100;
      tick();
      xcount = 8'd200;
      tick();
      while (k < S + 2) tick();
      chk("mid_phase_pre", {30'd0, spin_b, spin_a}, 32'd1);
      chk("mid_busy_pre", {31'd0, busy}, 32'd1);
      #3;
      reset = 1'b1;
      #1;
      chk("mid_rst_phase", {30'd0, spin_b, spin_a}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_dir", {31'd0, spin_dir}, 32'd1);
      do_reset(8'd200);
      for (int i = 0; i < 3 * S; i++) begin
         tick();
         chk("mid_quiet", {29'd0, spin_b, spin_a, busy}, 32'd0);
      end
      xcount = 8'd201;
      tick();
      chk("mid_resume_busy", {31'd0, busy}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
